tmr_scrub_ctrl: RTL

TMR_SCRUB_CTRL -- requirements
Module: tmr_scrub_ctrl

---
 rtl/tmr_scrub_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tmr_scrub_ctrl.sv
// rtl/tmr_scrub_ctrl.sv - TMR mismatch confirm/scrub/cooldown sequencer with per-replica fault tracking
module tmr_scrub_ctrl #(
  parameter int CNT_W        = 8,
  parameter int SCRUB_CYCLES = 2,
  parameter int COOLDOWN     = 4,
  parameter int FAULT_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [2:0]       mismatch_i,
  input  logic             clr_i,
  output logic             scrub_o,
  output logic [2:0]       scrub_mask_o,
  (* tmrx_error_sink *)
  output logic             err,
  output logic             fault_o,
  output logic [1:0]       fault_replica_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int SC_W = $clog2(SCRUB_CYCLES + 1);
  localparam int CD_W = $clog2(COOLDOWN + 1);

  typedef enum logic [2:0] {IDLE, CONFIRM, SCRUB, COOL, FAULT} state_t;

  state_t          state;
  logic [2:0]      mask;
  logic [2:0]      hit_cnt [4];
  logic [SC_W-1:0] sc_cnt;
  logic [CD_W-1:0] cd_cnt;
  logic            clr_pend;
  logic            fault_pend;
  logic [1:0]      fault_idx;

  logic            multi;
  logic            onehot;
  logic [1:0]      idx;
  logic [2:0]      hit_next;

  always_comb begin
    multi    = |(mismatch_i & (mismatch_i - 3'd1));
    onehot   = (mismatch_i != 3'd0) && !multi;
    idx      = mask[0] ? 2'd0 : (mask[1] ? 2'd1 : 2'd2);
    hit_next = (hit_cnt[idx] == 3'd7) ? 3'd7 : hit_cnt[idx] + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mask            <= '0;
      for (int i = 0; i < 4; i++) hit_cnt[i] <= '0;
      sc_cnt          <= '0;
      cd_cnt          <= '0;
      clr_pend        <= 1'b0;
      fault_pend      <= 1'b0;
      fault_idx       <= '0;
      scrub_o         <= 1'b0;
      scrub_mask_o    <= '0;
      err             <= 1'b0;
      fault_o         <= 1'b0;
      fault_replica_o <= '0;
      err_count_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_i) begin
            err_count_o <= '0;
            for (int i = 0; i < 4; i++) hit_cnt[i] <= '0;
          end else if (multi) begin
            state           <= FAULT;
            fault_o         <= 1'b1;
            err             <= 1'b1;
            fault_replica_o <= 2'd3;
          end else if (enable_i && onehot) begin
            mask  <= mismatch_i;
            state <= CONFIRM;
          end
        end
        CONFIRM: begin
          if (clr_i) begin
            err_count_o <= '0;
            for (int i = 0; i < 4; i++) hit_cnt[i] <= '0;
            state <= IDLE;
          end else if (multi) begin
            state           <= FAULT;
            fault_o         <= 1'b1;
            err             <= 1'b1;
            fault_replica_o <= 2'd3;
          end else if ((mismatch_i & mask) != 3'd0) begin
            // Entry cycle: count and flag now, drive scrub_o from the next cycle on
            state        <= SCRUB;
            sc_cnt       <= '0;
            err          <= 1'b1;
            err_count_o  <= (&err_count_o) ? err_count_o : err_count_o + CNT_W'(1);
            hit_cnt[idx] <= hit_next;
            fault_pend   <= (hit_next == 3'(FAULT_THRESH));
            fault_idx    <= idx;
            clr_pend     <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        SCRUB: begin
          if (clr_i) clr_pend <= 1'b1;
          if (sc_cnt == SC_W'(SCRUB_CYCLES)) begin
            scrub_o      <= 1'b0;
            scrub_mask_o <= '0;
            cd_cnt       <= '0;
            // A clear requested during the scrub wipes the counters, so any pending fault is moot
            if (clr_pend || clr_i) begin
              err_count_o <= '0;
              for (int i = 0; i < 4; i++) hit_cnt[i] <= '0;
              state <= COOL;
            end else if (fault_pend) begin
              state           <= FAULT;
              fault_o         <= 1'b1;
              err             <= 1'b1;
              fault_replica_o <= fault_idx;
            end else begin
              state <= COOL;
            end
          end else begin
            sc_cnt <= sc_cnt + SC_W'(1);
            if (sc_cnt == '0) begin
              scrub_o      <= 1'b1;
              scrub_mask_o <= mask;
              err          <= 1'b0;
            end
          end
        end
        COOL: begin
          if (clr_i) begin
            err_count_o <= '0;
            for (int i = 0; i < 4; i++) hit_cnt[i] <= '0;
            state <= IDLE;
          end else if (cd_cnt == CD_W'(COOLDOWN - 1)) begin
            state <= IDLE;
          end else begin
            cd_cnt <= cd_cnt + CD_W'(1);
          end
        end
        FAULT: begin
          if (clr_i) begin
            err_count_o <= '0;
            for (int i = 0; i < 4; i++) hit_cnt[i] <= '0;
            fault_o         <= 1'b0;
            fault_replica_o <= '0;
            err             <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
